instruction_fetch: RTL and testbench

- Instruction sequencer that sits directly upstream of the chip core.
- Holds a small loadable program store and a program counter.
- Presents one 16-bit opcode to the core for exactly four clock cycles, matching the core's four instruction phases: decode, read, operate, write.
- Advances through the program until a halt opcode or the end of the store.

---
 rtl/instruction_fetch.sv | 105 ++++++++++
 tb/tb_instruction_fetch.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction sequencer: holds each program word on OPCODE for the four core phases.
// Define FETCH_LOOP_EN to wrap from the last store word back to word 0 instead of halting.
module instruction_fetch #(
  parameter int          DEPTH   = 16,
  parameter int          ADDR_W  = 4,
  parameter logic [15:0] HALT_OP = 16'hFFFF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RUN,
  input  logic              LOAD_EN,
  input  logic [ADDR_W-1:0] LOAD_ADDR,
  input  logic [15:0]       LOAD_DATA,
  output logic [15:0]       OPCODE,
  output logic [1:0]        PHASE,
  output logic [ADDR_W-1:0] PC,
  output logic              BUSY,
  output logic              HALTED
);

  typedef enum logic [1:0] {IDLE, EXEC, HALT} state_t;

  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(DEPTH-1);

  state_t            state, state_nxt;
  logic [15:0]       opcode_nxt;
  logic [1:0]        phase_nxt;
  logic [ADDR_W-1:0] pc_nxt, pc_inc;
  logic              ld_ok;

  logic [15:0] mem [DEPTH];

  // Store is writable only when stopped and not starting this cycle; never reset.
  assign ld_ok  = (state != EXEC) && !RUN && LOAD_EN && ({1'b0, LOAD_ADDR} < DEPTH_W);
  assign pc_inc = PC + 1'b1;

  always_ff @(posedge CLK) begin
    if (ld_ok) mem[LOAD_ADDR] <= LOAD_DATA;
  end

  always_comb begin
    state_nxt  = state;
    opcode_nxt = OPCODE;
    phase_nxt  = PHASE;
    pc_nxt     = PC;
    case (state)
      IDLE, HALT: begin
        if (RUN) begin
          state_nxt  = EXEC;
          pc_nxt     = '0;
          opcode_nxt = mem[0];
          phase_nxt  = 2'd0;
        end
      end
      EXEC: begin
        if (PHASE != 2'd3) begin
          phase_nxt = PHASE + 2'd1;
        end else if (OPCODE == HALT_OP) begin
          state_nxt  = HALT;
          opcode_nxt = '0;
          phase_nxt  = 2'd0;
        end else if (PC == LAST_PC) begin
`ifdef FETCH_LOOP_EN
          pc_nxt     = '0;
          opcode_nxt = mem[0];
          phase_nxt  = 2'd0;
`else
          state_nxt  = HALT;
          opcode_nxt = '0;
          phase_nxt  = 2'd0;
`endif
        end else begin
          pc_nxt     = pc_inc;
          opcode_nxt = mem[pc_inc];
          phase_nxt  = 2'd0;
        end
      end
      default: begin
        state_nxt  = IDLE;
        opcode_nxt = '0;
        phase_nxt  = 2'd0;
        pc_nxt     = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      OPCODE <= '0;
      PHASE  <= 2'd0;
      PC     <= '0;
    end else begin
      state  <= state_nxt;
      OPCODE <= opcode_nxt;
      PHASE  <= phase_nxt;
      PC     <= pc_nxt;
    end
  end

  assign BUSY   = (state == EXEC);
  assign HALTED = (state == HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: the model expands the program store into the expected
// per-cycle trace of (busy, halted, pc, phase, opcode) and compares cycle by cycle.
module tb_instruction_fetch;
  localparam int          DEPTH   = 16;
  localparam int          ADDR_W  = 4;
  localparam logic [15:0] HALT_OP = 16'hFFFF;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              RUN = 1'b0;
  logic              LOAD_EN = 1'b0;
  logic [ADDR_W-1:0] LOAD_ADDR = '0;
  logic [15:0]       LOAD_DATA = '0;
  logic [15:0]       OPCODE;
  logic [1:0]        PHASE;
  logic [ADDR_W-1:0] PC;
  logic              BUSY;
  logic              HALTED;

  instruction_fetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HALT_OP(HALT_OP)) dut (
    .CLK(CLK), .RST_N(RST_N), .RUN(RUN), .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR),
    .LOAD_DATA(LOAD_DATA), .OPCODE(OPCODE), .PHASE(PHASE), .PC(PC), .BUSY(BUSY),
    .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;
  logic [15:0] mem_m [DEPTH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  function automatic logic [31:0] obs();
    return {8'b0, BUSY, HALTED, PC, PHASE, OPCODE};
  endfunction

  function automatic logic [31:0] ex(input bit b, input bit h, input int pc, input int ph,
                                     input logic [15:0] op);
    return {8'b0, b, h, ADDR_W'(pc), 2'(ph), op};
  endfunction

  task automatic load(input int addr, input logic [15:0] data);
    @(negedge CLK);
    LOAD_EN = 1'b1; LOAD_ADDR = ADDR_W'(addr); LOAD_DATA = data;
    @(negedge CLK);
    LOAD_EN = 1'b0;
    mem_m[addr] = data;
  endtask

  // Run the loaded program; optionally inject ignored inputs, a load alongside RUN,
  // or an asynchronous reset right after trace entry abort_at.
  task automatic run_prog(input int max_instr, input bit noise, input bit ld_run,
                          input int abort_at);
    logic [31:0] q[$];
    logic [15:0] op;
    int pc = 0;
    int ni = 0;
    bit halts = 0;
    while (ni < max_instr) begin
      op = mem_m[pc];
      for (int ph = 0; ph < 4; ph++) q.push_back(ex(1, 0, pc, ph, op));
      ni++;
      if (op == HALT_OP) begin halts = 1; break; end
      if (pc == DEPTH-1) begin
`ifdef FETCH_LOOP_EN
        pc = 0;
`else
        halts = 1;
        break;
`endif
      end else pc++;
    end
    @(negedge CLK);
    RUN = 1'b1;
    if (ld_run) begin LOAD_EN = 1'b1; LOAD_ADDR = '0; LOAD_DATA = 16'hBEEF; end
    for (int i = 0; i < q.size(); i++) begin
      @(negedge CLK);
      chk($sformatf("exec%0d", i), obs(), q[i]);
      if (i == abort_at) begin
        RUN = 1'b0; LOAD_EN = 1'b0; RST_N = 1'b0;
        #1;
        chk("mid_rst", obs(), 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        return;
      end
      if (noise && i < q.size()-1) begin
        RUN = 1'($urandom); LOAD_EN = 1'($urandom);
        LOAD_ADDR = ADDR_W'($urandom); LOAD_DATA = 16'($urandom);
      end else begin
        RUN = 1'b0; LOAD_EN = 1'b0;
      end
    end
    if (halts) begin
      @(negedge CLK);
      chk("halt", obs(), ex(0, 1, pc, 0, 16'h0));
    end else begin
      RST_N = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
    end
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_hold", obs(), 32'h0);
    RST_N = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("rst_idle", obs(), 32'h0);
    end

    load(0, 16'h1234); load(1, 16'h5678); load(2, 16'hFFFF);
    run_prog(100, 0, 0, -1);
    run_prog(100, 1, 0, -1);   // RUN/LOAD noise while executing
    run_prog(100, 0, 0, -1);   // store untouched by that noise
    run_prog(100, 0, 0, 6);    // reset at PC=1, PHASE=2
    run_prog(100, 0, 0, -1);
    run_prog(100, 0, 1, -1);   // load alongside RUN is dropped
    run_prog(100, 0, 0, -1);

    for (int a = 0; a < DEPTH; a++) load(a, 16'h0001);
    run_prog(17, 0, 0, -1);    // end of store

    repeat (6) begin
      int hpos;
      logic [15:0] d;
      hpos = $urandom_range(0, DEPTH + 3);
      for (int a = 0; a < DEPTH; a++) begin
        d = 16'($urandom);
        if (d == HALT_OP) d = 16'h0;
        if (a == hpos) d = HALT_OP;
        load(a, d);
      end
      run_prog(40, 1'($urandom), 0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
